// File: rtl/first_counter.sv
// Enabled up-counter that wraps from MAX_VALUE to zero.
// It flags the terminal value and pulses for one cycle after each wrap.
module first_counter #(
   parameter int unsigned           WIDTH     = 4,
   parameter logic [WIDTH-1:0]      MAX_VALUE = {WIDTH{1'b1}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] counter_out,
   output logic             terminal_count,
   output logic             wrap_pulse
);

   logic at_max;

   // terminal_count follows the count value itself, whatever enable is doing.
   assign at_max         = (counter_out == MAX_VALUE);
   assign terminal_count = at_max;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter_out <= '0;
         wrap_pulse  <= 1'b0;
      end else if (enable) begin
         if (at_max) begin
            counter_out <= '0;
            wrap_pulse  <= 1'b1;
         end else begin
            counter_out <= counter_out + 1'b1;
            wrap_pulse  <= 1'b0;
         end
      end else begin
         wrap_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_first_counter.sv
// Directed bench for first_counter: a default 4-bit instance and a
// 4-bit instance that wraps at 9.
module tb_first_counter;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [3:0] count;
   logic       tc;
   logic       wrap;

   logic       reset9;
   logic       enable9;
   logic [3:0] count9;
   logic       tc9;
   logic       wrap9;

   int n_checks;
   int n_pass;

   first_counter #(.WIDTH(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .counter_out    (count),
      .terminal_count (tc),
      .wrap_pulse     (wrap)
   );

   first_counter #(.WIDTH(4), .MAX_VALUE(4'd9)) dut9 (
      .clock          (clock),
      .reset          (reset9),
      .enable         (enable9),
      .counter_out    (count9),
      .terminal_count (tc9),
      .wrap_pulse     (wrap9)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required finish before 100000");
      $fatal(1, "watchdog");
   end

   // Reset pulse aligned to falling edges, spanning one rising edge.
   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      enable  = 1'b0;
      reset9  = 1'b0;
      enable9 = 1'b0;
      #5 reset = 1'b0;
      #1;
      n_checks++;
      if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count);
      else n_pass++;
      n_checks++;
      if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap);
      else n_pass++;
      n_checks++;
      if (tc !== 1'b0) $display("FAIL reset_tc: got %b want 0", tc);
      else n_pass++;
      #3;
      n_checks++;
      if (count !== 4'd0) $display("FAIL reset_hold_count: got %0d want 0", count);
      else n_pass++;
      #6 reset = 1'b1;
      reset9 = 1'b1;
   endtask

   task automatic test_hold();
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_checks++;
         if (count !== 4'd0) $display("FAIL hold_count[%0d]: got %0d want 0", i, count);
         else n_pass++;
         n_checks++;
         if (tc !== 1'b0) $display("FAIL hold_tc[%0d]: got %b want 0", i, tc);
         else n_pass++;
      end
   endtask

   task automatic test_count();
      enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         n_checks++;
         if (count !== 4'(i)) $display("FAIL count_step[%0d]: got %0d want %0d", i, count, i);
         else n_pass++;
      end
      enable = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_checks++;
         if (count !== 4'd10) $display("FAIL count_hold[%0d]: got %0d want 10", i, count);
         else n_pass++;
         n_checks++;
         if (wrap !== 1'b0) $display("FAIL count_hold_wrap[%0d]: got %b want 0", i, wrap);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_count;
      pulse_reset();
      n_checks++;
      if (count !== 4'd0) $display("FAIL wrap_start: got %0d want 0", count);
      else n_pass++;
      enable = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         @(negedge clock);
         exp_count = 4'(i % 16);
         n_checks++;
         if (count !== exp_count) $display("FAIL wrap_count[%0d]: got %0d want %0d", i, count, exp_count);
         else n_pass++;
         n_checks++;
         if (tc !== (i == 15)) $display("FAIL wrap_tc[%0d]: got %b want %b", i, tc, (i == 15));
         else n_pass++;
         n_checks++;
         if (wrap !== (i == 16)) $display("FAIL wrap_pulse[%0d]: got %b want %b", i, wrap, (i == 16));
         else n_pass++;
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid_count();
      pulse_reset();
      enable = 1'b1;
      repeat (7) @(negedge clock);
      n_checks++;
      if (count !== 4'd7) $display("FAIL mid_pre: got %0d want 7", count);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (count !== 4'd0) $display("FAIL mid_async_clear: got %0d want 0", count);
      else n_pass++;
      n_checks++;
      if (wrap !== 1'b0) $display("FAIL mid_async_wrap: got %b want 0", wrap);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if (count !== 4'd0) $display("FAIL mid_reset_wins: got %0d want 0", count);
      else n_pass++;
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (count !== 4'd1) $display("FAIL mid_resume: got %0d want 1", count);
      else n_pass++;
      enable = 1'b0;
   endtask

   task automatic test_param_override();
      logic [3:0] exp_count;
      @(negedge clock);
      n_checks++;
      if (count9 !== 4'd0) $display("FAIL p9_start: got %0d want 0", count9);
      else n_pass++;
      enable9 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         exp_count = 4'(i % 10);
         n_checks++;
         if (count9 !== exp_count) $display("FAIL p9_count[%0d]: got %0d want %0d", i, count9, exp_count);
         else n_pass++;
         n_checks++;
         if (tc9 !== (i == 9)) $display("FAIL p9_tc[%0d]: got %b want %b", i, tc9, (i == 9));
         else n_pass++;
         n_checks++;
         if (wrap9 !== (i == 10)) $display("FAIL p9_wrap[%0d]: got %b want %b", i, wrap9, (i == 10));
         else n_pass++;
      end
      enable9 = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_hold();
      test_count();
      test_wrap();
      test_reset_mid_count();
      test_param_override();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
